mem_access_unit: RTL
====================

# mem_access_unit

Parametrised memory access unit for the memory_system datapath: owns the MAR, MDR and an inferred word-addressed RAM, and runs multi-cycle single or burst read/write transactions with configurable wait states. It replaces the fixed 8-bit single-cycle MAR/MDR/memory path. The ALU/register-bank side loads addresses and data and starts a transaction. The unit reports busy, per-word beat and done.

## Interface
Parameters:
- DATA_WIDTH, 8, word width of MDR and RAM
- ADDR_WIDTH, 8, MAR width; RAM depth = 2**ADDR_WIDTH words
- WAIT_STATES, 1, wait cycles before each word transfer (0..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mar_sclr  in  1  synchronous MAR clear; also clears perr
- mar_en  in  1  load MAR from addr_in
- addr_in  in  ADDR_WIDTH  address from busC
- mdr_en  in  1  load MDR
- mdr_alu_n  in  1  MDR load source: 0 = alu_in; 1 is reserved for memory, so external loads are ignored
- alu_in  in  DATA_WIDTH  write data from ALU bus
- start  in  1  begin transaction; sampled only in IDLE
- wr_rdn  in  1  1 = write, 0 = read; sampled with start
- burst_len  in  2  words to transfer minus 1 (1..4 words)
- err_inj  in  1  store inverted parity on write beats (parity build only)
- mar_q  out  ADDR_WIDTH  MAR contents
- mdr_q  out  DATA_WIDTH  MDR contents
- busy  out  1  high in any state except IDLE
- beat  out  1  one-cycle pulse in each XFER cycle
- done  out  1  one-cycle pulse in DONE
- perr  out  1  sticky read parity error

## Operation
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - mar_sclr has priority over mar_en.
  - mdr_en with mdr_alu_n=0 loads alu_in.
  - start latches wr_rdn, remaining = burst_len and wait counter = WAIT_STATES.
  - Next state is WAIT, or XFER when WAIT_STATES=0.
- WAIT: counter decrements each cycle; on the cycle it reads 1 → XFER.
- XFER (1 cycle):
  - Write: mem[MAR] ← MDR.
  - Read: MDR ← mem[MAR].
  - beat=1.
  - If remaining=0 → DONE.
  - Otherwise MAR ← MAR+1 (mod 2**ADDR_WIDTH, wrap-around), remaining−1, reload the counter, → WAIT or XFER.
- DONE: done=1; → IDLE. MAR holds the last accessed address; there is no post-increment after the final beat.
- While busy:
  - start, mar_en and mar_sclr are ignored.
  - mdr_en/alu_in loads are accepted in WAIT and XFER of write bursts, so the host streams the next word.
  - In a write XFER the RAM takes the old MDR. A simultaneous load takes effect at the same edge for the next beat.
  - In read transactions external MDR loads are ignored.
- RAM contents are not reset.

## Timing
- Reset (asynchronous, rst low) forces:
  - state IDLE, MAR=0, MDR=0
  - busy=0, beat=0, done=0, perr=0
  - takes effect immediately and regardless of state.
- Reset asserted before the XFER edge aborts the transaction. That word is not written.
- Start sampled at edge E0:
  - busy rises after E0.
  - First XFER occupies the cycle after edge E0+WAIT_STATES.
- Read data:
  - visible on mdr_q in the cycle after the XFER of the last beat, which is the DONE cycle.
  - Each earlier word is visible from the cycle after its own beat until the next beat overwrites it.
- Busy cycles per transaction: (burst_len+1)·(WAIT_STATES+1)+1.
- done and beat are registered outputs. Never both high.
- start asserted in the DONE cycle is ignored. Earliest new start is sampled at the first IDLE edge.

## Configuration
- MEM_PARITY_EN defined:
  - RAM is DATA_WIDTH+1 wide. The extra bit is even parity of the data, inverted when err_inj=1 on a write beat.
  - Each read XFER checks parity. A mismatch sets perr at that edge.
  - perr stays set until mar_sclr in IDLE or reset.
- MEM_PARITY_EN undefined:
  - RAM is DATA_WIDTH wide.
  - perr is tied 0 and err_inj is ignored.

## Test plan
- Reset mid-WAIT during a write to 0x10 (WAIT_STATES=3):
  - all outputs return to 0 immediately.
  - A subsequent read of 0x10 must not return the aborted write data.
- Single write then read, WAIT_STATES=1: MAR=0x10, MDR=0xA5, write (busy 3 cycles, done once); then read 0x10 → mdr_q=0xA5 in the DONE cycle.
- Write burst, burst_len=3, MAR=0x3E, stream 0x11,0x22,0x33,0x44:
  - stored at 0x3E,0x3F,0x40,0x41.
  - Four beat pulses; mar_q=0x41 at done.
- Wrap-around: read burst, burst_len=1, MAR=0xFF, ADDR_WIDTH=8 → words from 0xFF then 0x00; mar_q=0x00 at done.
- WAIT_STATES=0: beats on consecutive cycles; start, mar_en and mar_sclr pulsed while busy have no effect.
- MEM_PARITY_EN:
  - write 0x5A with err_inj=1, then read → perr=1 after that read XFER; it stays 1 through a clean read and clears on mar_sclr.
  - Without the macro the same stimulus leaves perr=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR, MDR and a word-addressed RAM driven by a
// multi-cycle single/burst read/write FSM. Define MEM_PARITY_EN for parity RAM.
module mem_access_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mar_sclr_i,
    input  logic                  mar_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_in_i,
    input  logic                  mdr_en_i,
    input  logic                  mdr_alu_n_i,
    input  logic [DATA_WIDTH-1:0] alu_in_i,
    input  logic                  start_i,
    input  logic                  wr_rdn_i,
    input  logic [1:0]            burst_len_i,
    input  logic                  err_inj_i,
    output logic [ADDR_WIDTH-1:0] mar_q_o,
    output logic [DATA_WIDTH-1:0] mdr_q_o,
    output logic                  busy_o,
    output logic                  beat_o,
    output logic                  done_o,
    output logic                  perr_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef MEM_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   mar_q;
    logic [DATA_WIDTH-1:0]   mdr_q;
    logic                    wr_q;
    logic [1:0]              rem_q;
    logic [3:0]              cnt_q;
    logic                    busy_q;
    logic                    beat_q;
    logic                    done_q;

    logic [RAM_W-1:0]        mem [DEPTH];
    logic [RAM_W-1:0]        ram_wdata_d;
    logic [RAM_W-1:0]        ram_rdata;
    logic                    ram_we;
    logic                    host_load;

    assign host_load = mdr_en_i && !mdr_alu_n_i;
    assign ram_we    = (state_q == S_XFER) && wr_q;
    assign ram_rdata = mem[mar_q];

`ifdef MEM_PARITY_EN
    logic perr_q;
    logic rd_par_bad;
    // Stored bit is even parity of the data word, deliberately flipped for error injection.
    assign ram_wdata_d = {(^mdr_q) ^ err_inj_i, mdr_q};
    assign rd_par_bad  = ram_rdata[DATA_WIDTH] != (^ram_rdata[DATA_WIDTH-1:0]);
    assign perr_o      = perr_q;
`else
    assign ram_wdata_d = mdr_q;
    assign perr_o      = 1'b0 & err_inj_i;
`endif

    // RAM contents are never reset; reset aborts via the state register instead.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem[mar_q] <= ram_wdata_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            wr_q    <= 1'b0;
            rem_q   <= 2'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            beat_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            beat_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mar_sclr_i) begin
                        mar_q <= '0;
`ifdef MEM_PARITY_EN
                        perr_q <= 1'b0;
`endif
                    end else if (mar_en_i) begin
                        mar_q <= addr_in_i;
                    end
                    if (host_load) begin
                        mdr_q <= alu_in_i;
                    end
                    if (start_i) begin
                        wr_q   <= wr_rdn_i;
                        rem_q  <= burst_len_i;
                        cnt_q  <= WS;
                        busy_q <= 1'b1;
                        if (WS == 4'd0) begin
                            state_q <= S_XFER;
                            beat_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wr_q && host_load) begin
                        mdr_q <= alu_in_i;
                    end
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_XFER;
                        beat_q  <= 1'b1;
                    end
                end
                S_XFER: begin
                    // A host load here lands in MDR while the RAM captures the old word.
                    if (wr_q) begin
                        if (host_load) begin
                            mdr_q <= alu_in_i;
                        end
                    end else begin
                        mdr_q <= ram_rdata[DATA_WIDTH-1:0];
`ifdef MEM_PARITY_EN
                        if (rd_par_bad) begin
                            perr_q <= 1'b1;
                        end
`endif
                    end
                    if (rem_q == 2'd0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        mar_q <= mar_q + ADDR_WIDTH'(1);
                        rem_q <= rem_q - 2'd1;
                        cnt_q <= WS;
                        if (WS == 4'd0) begin
                            state_q <= S_XFER;
                            beat_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mar_q_o = mar_q;
    assign mdr_q_o = mdr_q;
    assign busy_o  = busy_q;
    assign beat_o  = beat_q;
    assign done_o  = done_q;

endmodule
